// File: rtl/sd_boot_lader.sv
// rtl/sd_boot_lader.sv - SD card boot loader: length header, N data words into RAM, CPU reset release
// Paced SD reads with timeout, RAM write handshake, size check and restart on Start.
module sd_boot_lader #(
  parameter int WORDSIZE   = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_BASE   = 0,
  parameter int MAX_WORDS  = 32768,
  parameter int PACING     = 31,
  parameter int TIMEOUT    = 65535,
  parameter int AUTO_START = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  SDBusy,
  input  logic [WORDSIZE-1:0]   SDDaten,
  output logic                  SDLesen,
  output logic [ADDR_WIDTH-1:0] SDAdresse,
  output logic                  RAMSchreiben,
  output logic [ADDR_WIDTH-1:0] RAMAdresse,
  output logic [WORDSIZE-1:0]   RAMDaten,
  input  logic                  RAMGeschrieben,
  output logic                  CPUReset,
  output logic                  Fertig,
  output logic                  Fehler,
  output logic [ADDR_WIDTH-1:0] WorteGeladen
);

  typedef enum logic [3:0] {
    S_IDLE, S_PAUSE, S_REQ, S_WAIT_BUSY, S_WAIT_DATA, S_CHECK, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic                  auto_q, auto_d;
  logic                  hdr_q, hdr_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic [ADDR_WIDTH-1:0] worte_q, worte_d;
  logic [WORDSIZE-1:0]   data_q, data_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  sd_lesen_q, sd_lesen_d;
  logic [ADDR_WIDTH-1:0] sd_adresse_q, sd_adresse_d;
  logic                  ram_schreiben_q, ram_schreiben_d;
  logic [ADDR_WIDTH-1:0] ram_adresse_q, ram_adresse_d;
  logic [WORDSIZE-1:0]   ram_daten_q, ram_daten_d;
  logic                  start_load;
  logic                  timed_out;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q         <= S_IDLE;
      auto_q          <= (AUTO_START != 0);
      hdr_q           <= 1'b1;
      idx_q           <= '0;
      n_q             <= '0;
      worte_q         <= '0;
      data_q          <= '0;
      cnt_q           <= '0;
      sd_lesen_q      <= 1'b0;
      sd_adresse_q    <= '0;
      ram_schreiben_q <= 1'b0;
      ram_adresse_q   <= ADDR_WIDTH'(RAM_BASE);
      ram_daten_q     <= '0;
    end else begin
      state_q         <= state_d;
      auto_q          <= auto_d;
      hdr_q           <= hdr_d;
      idx_q           <= idx_d;
      n_q             <= n_d;
      worte_q         <= worte_d;
      data_q          <= data_d;
      cnt_q           <= cnt_d;
      sd_lesen_q      <= sd_lesen_d;
      sd_adresse_q    <= sd_adresse_d;
      ram_schreiben_q <= ram_schreiben_d;
      ram_adresse_q   <= ram_adresse_d;
      ram_daten_q     <= ram_daten_d;
    end
  end

  // cnt_q is shared: pacing in PAUSE, timeout across WAIT_BUSY+WAIT_DATA, and in WRITE.
  assign timed_out = (cnt_q >= 32'(TIMEOUT));

  always_comb begin
    state_d         = state_q;
    auto_d          = 1'b0;
    hdr_d           = hdr_q;
    idx_d           = idx_q;
    n_d             = n_q;
    worte_d         = worte_q;
    data_d          = data_q;
    cnt_d           = cnt_q + 32'd1;
    sd_lesen_d      = 1'b0;
    sd_adresse_d    = sd_adresse_q;
    ram_schreiben_d = ram_schreiben_q;
    ram_adresse_d   = ram_adresse_q;
    ram_daten_d     = ram_daten_q;
    start_load      = 1'b0;

    case (state_q)
      S_IDLE: start_load = Start || auto_q;
      S_PAUSE: begin
        if (cnt_q + 32'd1 >= 32'(PACING)) state_d = S_REQ;
      end
      S_REQ: begin
        if (!SDBusy) begin
          sd_lesen_d   = 1'b1;
          sd_adresse_d = idx_q;
          state_d      = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (SDBusy)         state_d = S_WAIT_DATA;
        else if (timed_out) state_d = S_ERROR;
      end
      S_WAIT_DATA: begin
        if (!SDBusy) begin
          data_d  = SDDaten;
          state_d = S_CHECK;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end
      end
      S_CHECK: begin
        if (hdr_q) begin
          if (data_q == '0 || data_q > WORDSIZE'(MAX_WORDS)) begin
            state_d = S_ERROR;
          end else begin
            n_d     = ADDR_WIDTH'(data_q);
            hdr_d   = 1'b0;
            idx_d   = ADDR_WIDTH'(1);
            state_d = S_PAUSE;
          end
        end else begin
          ram_adresse_d   = ADDR_WIDTH'(RAM_BASE) + idx_q - ADDR_WIDTH'(1);
          ram_daten_d     = data_q;
          ram_schreiben_d = 1'b1;
          state_d         = S_WRITE;
        end
      end
      S_WRITE: begin
        if (RAMGeschrieben) begin
          ram_schreiben_d = 1'b0;
          worte_d         = worte_q + ADDR_WIDTH'(1);
          idx_d           = idx_q + ADDR_WIDTH'(1);
          state_d         = (worte_q + ADDR_WIDTH'(1) == n_q) ? S_DONE : S_PAUSE;
        end else if (timed_out) begin
          ram_schreiben_d = 1'b0;
          state_d         = S_ERROR;
        end
      end
      S_DONE:  start_load = Start;
      S_ERROR: start_load = Start;
      default: state_d = S_IDLE;
    endcase

    if (start_load) begin
      state_d = S_PAUSE;
      hdr_d   = 1'b1;
      idx_d   = '0;
      worte_d = '0;
    end

    if (state_d != state_q && !(state_q == S_WAIT_BUSY && state_d == S_WAIT_DATA)) cnt_d = '0;
  end

  assign SDLesen      = sd_lesen_q;
  assign SDAdresse    = sd_adresse_q;
  assign RAMSchreiben = ram_schreiben_q;
  assign RAMAdresse   = ram_adresse_q;
  assign RAMDaten     = ram_daten_q;
  assign WorteGeladen = worte_q;
  assign CPUReset     = (state_q != S_DONE);
  assign Fertig       = (state_q == S_DONE);
  assign Fehler       = (state_q == S_ERROR);

endmodule

// File: tb/tb_sd_boot_lader.sv
// tb/tb_sd_boot_lader.sv - directed bench for sd_boot_lader with reactive SD and RAM models
// Two instances: A (auto start, PACING=3, base 0) and B (manual start, PACING=0, base 0x100).
module tb_sd_boot_lader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        sel;
  logic        sd_busy;
  logic        ack;
  logic [31:0] sd_daten;

  logic        a_lesen, a_schr, a_cpu, a_fertig, a_fehler;
  logic [31:0] a_sdaddr, a_raddr, a_rdata, a_worte;
  logic        b_lesen, b_schr, b_cpu, b_fertig, b_fehler;
  logic [31:0] b_sdaddr, b_raddr, b_rdata, b_worte;

  logic        a_start, b_start, a_busy, b_busy, a_ack, b_ack;
  assign a_start = sel ? 1'b0 : start;
  assign b_start = sel ? start : 1'b0;
  assign a_busy  = sel ? 1'b0 : sd_busy;
  assign b_busy  = sel ? sd_busy : 1'b0;
  assign a_ack   = sel ? 1'b0 : ack;
  assign b_ack   = sel ? ack : 1'b0;

  logic        m_lesen, m_schr, m_cpu, m_fertig, m_fehler;
  logic [31:0] m_sdaddr, m_raddr, m_rdata, m_worte;
  assign m_lesen  = sel ? b_lesen  : a_lesen;
  assign m_schr   = sel ? b_schr   : a_schr;
  assign m_cpu    = sel ? b_cpu    : a_cpu;
  assign m_fertig = sel ? b_fertig : a_fertig;
  assign m_fehler = sel ? b_fehler : a_fehler;
  assign m_sdaddr = sel ? b_sdaddr : a_sdaddr;
  assign m_raddr  = sel ? b_raddr  : a_raddr;
  assign m_rdata  = sel ? b_rdata  : a_rdata;
  assign m_worte  = sel ? b_worte  : a_worte;

  sd_boot_lader #(.WORDSIZE(32), .ADDR_WIDTH(32), .RAM_BASE(0), .MAX_WORDS(8),
                  .PACING(3), .TIMEOUT(20), .AUTO_START(1)) u_a (
    .Clock(clk), .Reset(rst), .Start(a_start), .SDBusy(a_busy), .SDDaten(sd_daten),
    .SDLesen(a_lesen), .SDAdresse(a_sdaddr), .RAMSchreiben(a_schr), .RAMAdresse(a_raddr),
    .RAMDaten(a_rdata), .RAMGeschrieben(a_ack), .CPUReset(a_cpu), .Fertig(a_fertig),
    .Fehler(a_fehler), .WorteGeladen(a_worte));

  sd_boot_lader #(.WORDSIZE(32), .ADDR_WIDTH(32), .RAM_BASE('h100), .MAX_WORDS(8),
                  .PACING(0), .TIMEOUT(20), .AUTO_START(0)) u_b (
    .Clock(clk), .Reset(rst), .Start(b_start), .SDBusy(b_busy), .SDDaten(sd_daten),
    .SDLesen(b_lesen), .SDAdresse(b_sdaddr), .RAMSchreiben(b_schr), .RAMAdresse(b_raddr),
    .RAMDaten(b_rdata), .RAMGeschrieben(b_ack), .CPUReset(b_cpu), .Fertig(b_fertig),
    .Fehler(b_fehler), .WorteGeladen(b_worte));

  int checks = 0;
  int errors = 0;

  logic [31:0] sd_mem [16];
  logic [31:0] sd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [31:0] hang_addr = 32'hFFFF_FFFF;
  logic [31:0] sd_cur;
  int sd_lat = 3;
  int ram_lat = 2;
  int sd_cnt, wr_cnt;
  int excl_err = 0, lesen_err = 0, schr_rise = 0;
  logic prev_lesen = 1'b0, prev_schr = 1'b0;

  // SD card and RAM responders plus protocol monitors, all acting on the falling edge.
  initial begin
    sd_busy = 1'b0; ack = 1'b0; sd_daten = '0; sd_cnt = 0; wr_cnt = 0; sd_cur = '0;
    forever begin
      @(negedge clk);
      if (m_lesen && m_schr) excl_err++;
      if (m_lesen && prev_lesen) lesen_err++;
      if (m_schr && !prev_schr) schr_rise++;
      prev_lesen = m_lesen;
      prev_schr  = m_schr;
      if (sd_busy) begin
        if (sd_cnt > 0) sd_cnt--;
        else if (sd_cur != hang_addr) sd_busy = 1'b0;
      end else if (m_lesen) begin
        sd_cur   = m_sdaddr;
        sd_log.push_back(m_sdaddr);
        sd_daten = sd_mem[m_sdaddr[3:0]];
        sd_busy  = 1'b1;
        sd_cnt   = sd_lat;
      end
      if (ack) begin
        ack = 1'b0;
      end else if (m_schr) begin
        wr_cnt++;
        if (wr_cnt >= ram_lat) begin
          ack    = 1'b1;
          wr_cnt = 0;
          wr_addr_log.push_back(m_raddr);
          wr_data_log.push_back(m_rdata);
        end
      end else begin
        wr_cnt = 0;
      end
    end
  end

  task automatic clear_logs();
    sd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    schr_rise = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int maxc);
    int n = 0;
    while (!(m_fertig || m_fehler) && n < maxc) begin
      @(negedge clk); n++;
    end
    checks++;
    if (!(m_fertig || m_fehler)) begin
      errors++;
      $display("FAIL %s: load did not end, fertig=%0b fehler=%0b, required end within %0d cycles",
               name, m_fertig, m_fehler, maxc);
    end
  endtask

  task automatic test_reset();
    logic [166:0] obs, exp_v;
    rst = 1'b1; start = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    obs   = {a_lesen, a_sdaddr, a_schr, a_raddr, a_rdata, a_cpu, a_fertig, a_fehler, a_worte};
    exp_v = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL reset_a: got %h required %h", obs, exp_v);
    end
    obs   = {b_lesen, b_sdaddr, b_schr, b_raddr, b_rdata, b_cpu, b_fertig, b_fehler, b_worte};
    exp_v = {1'b0, 32'h0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL reset_b: got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_auto_load();
    sd_mem[0] = 32'd4;
    for (int i = 1; i <= 4; i++) sd_mem[i] = 32'hA0 + 32'(i - 1);
    clear_logs();
    rst = 1'b0;
    wait_end("auto_load", 400);
    checks++;
    if ({m_fertig, m_cpu, m_fehler, m_worte} !== {1'b1, 1'b0, 1'b0, 32'd4}) begin
      errors++;
      $display("FAIL auto_status: fertig=%0b cpu=%0b fehler=%0b worte=%0d required 1 0 0 4",
               m_fertig, m_cpu, m_fehler, m_worte);
    end
    checks++;
    if (sd_log.size() != 5) begin
      errors++; $display("FAIL auto_sd_count: got %0d required 5", sd_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (sd_log[i] !== 32'(i)) begin
          errors++; $display("FAIL auto_sd_addr[%0d]: got %0h required %0h", i, sd_log[i], i);
        end
      end
    end
    checks++;
    if (wr_addr_log.size() != 4) begin
      errors++; $display("FAIL auto_wr_count: got %0d required 4", wr_addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({wr_addr_log[i], wr_data_log[i]} !== {32'(i), 32'hA0 + 32'(i)}) begin
          errors++;
          $display("FAIL auto_wr[%0d]: got addr %0h data %0h required %0h %0h",
                   i, wr_addr_log[i], wr_data_log[i], i, 32'hA0 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_bad_header();
    logic [31:0] hdrs [2];
    hdrs[0] = 32'd0;
    hdrs[1] = 32'd9;
    for (int k = 0; k < 2; k++) begin
      sd_mem[0] = hdrs[k];
      clear_logs();
      pulse_start();
      checks++;
      if ({m_cpu, m_fertig, m_fehler} !== 3'b100) begin
        errors++;
        $display("FAIL bad_hdr%0d_restart: cpu/fertig/fehler got %b required 100", k,
                 {m_cpu, m_fertig, m_fehler});
      end
      wait_end("bad_hdr", 200);
      checks++;
      if ({m_fehler, m_cpu, m_worte, 32'(schr_rise)} !== {1'b1, 1'b1, 32'd0, 32'd0}) begin
        errors++;
        $display("FAIL bad_hdr%0d: fehler=%0b cpu=%0b worte=%0d wr_pulses=%0d required 1 1 0 0",
                 k, m_fehler, m_cpu, m_worte, schr_rise);
      end
    end
  endtask

  task automatic test_timeout();
    sd_mem[0] = 32'd3;
    for (int i = 1; i <= 3; i++) sd_mem[i] = 32'hD0 + 32'(i);
    hang_addr = 32'd2;
    clear_logs();
    pulse_start();
    wait_end("timeout", 400);
    checks++;
    if ({m_fehler, m_cpu, m_schr, m_worte} !== {1'b1, 1'b1, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL timeout_state: fehler=%0b cpu=%0b schr=%0b worte=%0d required 1 1 0 1",
               m_fehler, m_cpu, m_schr, m_worte);
    end
    hang_addr = 32'hFFFF_FFFF;
    clear_logs();
    pulse_start();
    wait_end("timeout_reload", 400);
    checks++;
    if ({m_fertig, m_worte, 32'(wr_data_log.size())} !== {1'b1, 32'd3, 32'd3}) begin
      errors++;
      $display("FAIL timeout_reload: fertig=%0b worte=%0d writes=%0d required 1 3 3",
               m_fertig, m_worte, wr_data_log.size());
    end else begin
      checks++;
      if ({wr_addr_log[2], wr_data_log[2]} !== {32'd2, 32'hD3}) begin
        errors++;
        $display("FAIL timeout_reload_last: got %0h %0h required 2 d3", wr_addr_log[2], wr_data_log[2]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int n;
    sd_mem[0] = 32'd2; sd_mem[1] = 32'hB0; sd_mem[2] = 32'hB1;
    clear_logs();
    pulse_start();
    checks++;
    if ({m_cpu, m_fertig} !== 2'b10) begin
      errors++; $display("FAIL done_restart: cpu/fertig got %b required 10", {m_cpu, m_fertig});
    end
    n = 0;
    while (!m_lesen && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    pulse_start();
    n = 0;
    while (!m_schr && n < 100) begin @(negedge clk); n++; end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("ignored_start", 300);
    checks++;
    if ({m_fertig, m_worte, 32'(sd_log.size()), 32'(wr_data_log.size())} !==
        {1'b1, 32'd2, 32'd3, 32'd2}) begin
      errors++;
      $display("FAIL ignored_start: fertig=%0b worte=%0d reads=%0d writes=%0d required 1 2 3 2",
               m_fertig, m_worte, sd_log.size(), wr_data_log.size());
    end else begin
      checks++;
      if ({sd_log[2], wr_addr_log[1], wr_data_log[1]} !== {32'd2, 32'd1, 32'hB1}) begin
        errors++;
        $display("FAIL ignored_start_seq: sd=%0h addr=%0h data=%0h required 2 1 b1",
                 sd_log[2], wr_addr_log[1], wr_data_log[1]);
      end
    end
  endtask

  task automatic test_base_single();
    sel = 1'b1;
    sd_mem[0] = 32'd1; sd_mem[1] = 32'hC0;
    clear_logs();
    pulse_start();
    wait_end("base_single", 200);
    checks++;
    if ({m_fertig, m_cpu, m_worte, 32'(wr_addr_log.size()), 32'(sd_log.size())} !==
        {1'b1, 1'b0, 32'd1, 32'd1, 32'd2}) begin
      errors++;
      $display("FAIL base_single: fertig=%0b cpu=%0b worte=%0d writes=%0d reads=%0d required 1 0 1 1 2",
               m_fertig, m_cpu, m_worte, wr_addr_log.size(), sd_log.size());
    end else begin
      checks++;
      if ({wr_addr_log[0], wr_data_log[0]} !== {32'h100, 32'hC0}) begin
        errors++;
        $display("FAIL base_addr: got %0h %0h required 100 c0", wr_addr_log[0], wr_data_log[0]);
      end
    end
    checks++;
    if (excl_err != 0 || lesen_err != 0) begin
      errors++;
      $display("FAIL exclusivity: overlap=%0d long_read=%0d required 0 0", excl_err, lesen_err);
    end
  endtask

  task automatic test_reset_in_write();
    logic [166:0] obs, exp_v;
    int n;
    sd_mem[0] = 32'd2; sd_mem[1] = 32'hE0; sd_mem[2] = 32'hE1;
    clear_logs();
    pulse_start();
    n = 0;
    while (!m_schr && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (m_schr !== 1'b1) begin
      errors++; $display("FAIL rst_write_reach: schr=%0b required 1", m_schr);
    end
    rst = 1'b1;
    @(negedge clk);
    obs   = {b_lesen, b_sdaddr, b_schr, b_raddr, b_rdata, b_cpu, b_fertig, b_fehler, b_worte};
    exp_v = {1'b0, 32'h0, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL rst_write: got %h required %h", obs, exp_v);
    end
    rst = 1'b0;
    clear_logs();
    repeat (10) @(negedge clk);
    checks++;
    if ({32'(sd_log.size()), b_cpu, b_fertig} !== {32'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL idle_hold: reads=%0d cpu=%0b fertig=%0b required 0 1 0",
               sd_log.size(), b_cpu, b_fertig);
    end
    pulse_start();
    wait_end("rst_reload", 200);
    checks++;
    if ({b_fertig, b_worte} !== {1'b1, 32'd2}) begin
      errors++;
      $display("FAIL rst_reload: fertig=%0b worte=%0d required 1 2", b_fertig, b_worte);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sd_mem[i] = '0;
    test_reset();
    test_auto_load();
    test_bad_header();
    test_timeout();
    test_ignored_start();
    test_base_single();
    test_reset_in_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
